mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Execute-stage sequencer for multi-cycle multiply. Accepts a decoded ALU select code plus operands from the EX stage.
- When the code is MUL (6'b001010), it runs an iterative radix-2 shift-add multiply over XLEN cycles and stalls upstream pipeline registers while busy.
- It presents the low XLEN bits of the product with a valid/ready handshake to writeback.
- All other ALU codes pass the single-cycle ALU untouched; this block ignores them.

Parameters:
- XLEN, 32, operand and result width.
- MUL_CODE, 6'b001010, alu_select value that triggers a multiply.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX stage holds a valid instruction.
- alu_select  in  6  decoded ALU operation code.
- op_a  in  XLEN  multiplicand (rs1 value).
- op_b  in  XLEN  multiplier (rs2 value).
- flush  in  1  branch/jump squash; abandons any multiply in progress.
- in_ready  out  1  block can accept a new multiply.
- stall  out  1  freeze IF/ID/EX pipeline registers.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes result.
- result  out  XLEN  low XLEN bits of op_a*op_b.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the rising edge of clk and has priority over every other input.
- Reset values: state=IDLE, in_ready=1, stall=0, out_valid=0, result=0, internal acc/mcand/mplier/count=0.
- States: IDLE, BUSY, DONE.
- Accept: accept = in_valid & in_ready & (alu_select==MUL_CODE) & ~flush.
  - On accept in cycle T: acc<=0, mcand<=op_a, mplier<=op_b, count<=0, state<=BUSY.
  - in_valid with any other code is ignored; state stays IDLE.
- BUSY iteration (one per cycle):
  - If mplier[0], then acc<=acc+mcand, truncated to XLEN bits.
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - When count reaches XLEN-1 in a BUSY cycle, state<=DONE after that update.
- Latency: out_valid rises in cycle T+XLEN+1 (T+33 at default XLEN).
- DONE: out_valid=1, result=acc. Both hold stable until out_ready=1. On the cycle out_ready=1: state<=IDLE, out_valid<=0 next cycle.
- Output rules:
  - in_ready=1 only in IDLE.
  - stall = (state==BUSY) | (state==DONE & ~out_ready).
  - stall is also 1 in the accept cycle itself (combinational on accept), so the mul instruction is held in EX.
- Back-to-back multiplies: a new multiply is accepted only in IDLE. Minimum spacing is one IDLE cycle after the handshake.
- flush:
  - In BUSY or DONE: state<=IDLE next cycle, out_valid<=0, no result delivered.
  - flush beats accept in the same cycle.
  - flush and out_ready together in DONE: treated as flush (no writeback asserted by this block).
- reset mid-operation: returns to IDLE with reset values next cycle; partial product discarded.
- Arithmetic: result is unsigned modulo 2^XLEN. This equals the signed low half, so no sign handling is required.
- Overflow wraps silently; no flags.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: in BUSY, if the updated mplier equals 0, state<=DONE after that cycle regardless of count. Latency becomes T+1+max(1, index of highest set bit of op_b + 1). Examples: op_b=0 gives DONE at T+2; op_b=5 gives DONE at T+4.
- Undefined: fixed latency T+XLEN+1 for all operands. The zero-detect logic is not generated.

Test Plan:
- Reset, then in_valid=1, alu_select=6'b001010, op_a=3, op_b=5 at cycle T -> stall=1 for T..T+32, out_valid=1 at T+33, result=15; out_ready=1 at T+33 -> IDLE and in_ready=1 at T+34.
- op_a=32'hFFFF_FFFF, op_b=32'h0000_0002 -> result=32'hFFFF_FFFE (wrap); op_a=32'h0001_0000, op_b=32'h0001_0000 -> result=0.
- in_valid=1, alu_select=6'b000000 (add) -> no state change, stall=0, out_valid stays 0.
- Accept mul, assert flush at T+10 -> IDLE at T+11, out_valid never rises; a new mul accepted at T+11 completes at T+11+33 with the correct product.
- Hold out_ready=0 for 5 cycles after DONE -> out_valid and result stable, stall=1; then out_ready=1 -> stall=0 the same cycle. Separately, assert reset at T+20 -> all outputs at reset values at T+21.
- With MUL_EARLY_EXIT_EN: op_a=7, op_b=0 -> out_valid at T+2, result=0; op_a=7, op_b=5 -> out_valid at T+4, result=35.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative radix-2 shift-add multiplier sequencer for the EX stage; stalls the pipeline while busy.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl #(
  parameter int          XLEN     = 32,
  parameter logic [5:0]  MUL_CODE = 6'b001010,
  parameter int          CNT_W    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [5:0]      alu_select,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            in_ready,
  output logic            stall,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e           state_q, state_d;
  logic [XLEN-1:0]  acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, mplier_nx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, accept, last;
  always_comb begin
    accept      = in_valid & in_ready_q & (alu_select == MUL_CODE) & ~flush;
    mplier_nx   = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
    last        = (count_q == CNT_W'(XLEN - 1)) | (mplier_nx == '0);
`else
    last        = count_q == CNT_W'(XLEN - 1);
`endif
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d    = '0;
        mcand_d  = op_a;
        mplier_d = op_b;
        count_d  = '0;
        state_d  = BUSY;
      end
      BUSY: if (flush) state_d = IDLE;
      else begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nx;
        count_d  = count_q + 1'b1;
        state_d  = last ? DONE : BUSY;
      end
      DONE: state_d = (flush | out_ready) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  // stall covers the accept cycle so the mul instruction stays in EX
  assign stall     = accept | (state_q == BUSY) | ((state_q == DONE) & ~out_ready);
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = acc_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: randomized scoreboard bench for mul_seq_ctrl with a product/latency reference model.
module tb_mul_seq_ctrl;
  localparam int         XLEN = 32;
  localparam logic [5:0] MUL  = 6'b001010;
  logic            clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [5:0]      alu_select = 0;
  logic [XLEN-1:0] op_a = 0, op_b = 0, result;
  logic            in_ready, stall, out_valid;
  int              cyc = 0, checks = 0, errors = 0;
  typedef struct { logic [XLEN-1:0] res; int due; } exp_t;
  exp_t sb[$];
  logic pv = 0;

  mul_seq_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_select(alu_select),
    .op_a(op_a), .op_b(op_b), .flush(flush), .in_ready(in_ready), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, exp);
    end
  endtask

  function automatic int lat(input logic [XLEN-1:0] b);
    int n;
    n = 0;
`ifdef MUL_EARLY_EXIT_EN
    for (int i = 0; i < XLEN; i++) if (b[i]) n = i + 1;
    return 1 + ((n < 1) ? 1 : n);
`else
    return XLEN + 1 + n;
`endif
  endfunction

  function automatic logic [5:0] nonmul();
    logic [5:0] c;
    c = 6'($urandom_range(63));
    return (c == MUL) ? 6'd0 : c;
  endfunction

  // monitor: every valid cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid && !flush) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        if (!pv) chk("latency", cyc, sb[0].due);
        chk("result", result, sb[0].res);
        if (out_ready) void'(sb.pop_front());
      end
    end
    pv = out_valid;
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    reset = 0; in_valid = 1'($urandom); alu_select = nonmul(); op_a = $urandom; op_b = $urandom;
    flush = 1'($urandom); out_ready = 1'($urandom);
    @(negedge clk);
    chk("idle_ready", in_ready, 1); chk("idle_stall", stall, 0); chk("idle_valid", out_valid, 0);
  endtask

  task automatic do_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int hold, input int fl_at, input int rs_at);
    int t0, due, c, h;
    logic busy, fin;
    logic [XLEN-1:0] p;
    @(posedge clk); #1;
    reset = 0; in_valid = 1; alu_select = MUL; op_a = a; op_b = b; flush = 0; out_ready = 0;
    t0 = cyc; due = t0 + lat(b); h = hold; p = a * b; fin = 0;
    sb.push_back('{res: p, due: due});
    @(negedge clk);
    chk("accept_ready", in_ready, 1); chk("accept_stall", stall, 1);
    for (int n = 0; n < 300 && !fin; n++) begin
      @(posedge clk); #1;
      c = cyc; busy = c < due;
      in_valid = 1'($urandom); op_a = $urandom; op_b = $urandom; flush = 0; reset = 0;
      alu_select = (busy && $urandom_range(1) == 1) ? MUL : nonmul();
      out_ready = !busy && h == 0;
      if (fl_at > 0 && c == t0 + fl_at) begin
        flush = 1; out_ready = 1'($urandom); void'(sb.pop_back()); fin = 1;
      end else if (rs_at > 0 && c == t0 + rs_at) begin
        reset = 1; void'(sb.pop_back()); fin = 1;
      end
      @(negedge clk);
      if (!reset) begin
        chk("busy_ready", in_ready, 0);
        chk("stall", stall, busy | !out_ready);
      end
      if (!busy && !fin) begin
        if (h == 0) fin = 1;
        else h--;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (reset) begin
      @(posedge clk); #1;
      reset = 0; in_valid = 0; flush = 0; out_ready = 0;
      @(negedge clk);
      chk("rst_ready", in_ready, 1); chk("rst_stall", stall, 0);
      chk("rst_valid", out_valid, 0); chk("rst_result", result, 0);
    end
  endtask

  initial begin
    int kind, hold, l;
    logic [XLEN-1:0] a, b;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", in_ready, 1); chk("reset_stall", stall, 0);
    chk("reset_valid", out_valid, 0); chk("reset_result", result, 0);
    do_mul(3, 5, 0, 0, 0);
    idle_cycle();
    do_mul(32'hFFFF_FFFF, 32'h2, 1, 0, 0);
    do_mul(32'h0001_0000, 32'h0001_0000, 0, 0, 0);
    repeat (3) idle_cycle();
    do_mul(32'h1234_5678, 32'h9ABC_DEF1, 0, 10, 0);
    do_mul(32'd12345, 32'd6789, 5, 0, 0);
    do_mul(32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0, 20);
    do_mul(7, 0, 0, 0, 0);
    do_mul(7, 5, 2, 0, 0);
    for (int t = 0; t < 50; t++) begin
      a = $urandom;
      b = ($urandom_range(3) == 0) ? XLEN'($urandom_range(15)) : $urandom;
      kind = $urandom_range(9); hold = $urandom_range(3); l = lat(b);
      if (kind < 2) do_mul(a, b, hold, 1 + $urandom_range(l + hold - 1), 0);
      else if (kind == 2) do_mul(a, b, hold, 0, 1 + $urandom_range(l - 2));
      else do_mul(a, b, hold, 0, 0);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();
    chk("sb_empty", XLEN'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
